// File: rtl/me_stream_core.sv
// ---------------------------------------------------------------------------
// me_stream_core
// Modular exponentiation x^y mod m over K-bit operands, using left-to-right
// square-and-multiply built on a bit-serial interleaved modular multiplier.
// The result is streamed out least significant W-bit word first over a
// valid/ready handshake.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   me_start   start request, only honoured in IDLE
//   me_x       base (must be < me_m)
//   me_y       exponent
//   me_m       modulus (must be nonzero)
//   me_busy    operation in progress
//   me_err     one-cycle pulse when the operand check fails
//   me_result  current result word
//   me_valid   me_result holds a valid word
//   me_ready   downstream accepts the word on me_valid & me_ready
//   me_last    high with the final word
//
// Build option: define ME_CONST_TIME_EN to run a multiply after every
// squaring, so that latency does not depend on the exponent.
// ---------------------------------------------------------------------------
module me_stream_core #(
  parameter int K = 2048,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         me_start,
  input  logic [K-1:0] me_x,
  input  logic [K-1:0] me_y,
  input  logic [K-1:0] me_m,
  output logic         me_busy,
  output logic         me_err,
  output logic [W-1:0] me_result,
  output logic         me_valid,
  input  logic         me_ready,
  output logic         me_last
);

  localparam int NW = K / W;
  localparam int CW = $clog2(K);
  localparam int JW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(K - 1);
  localparam logic [JW-1:0] LAST_WORD = JW'(NW - 1);

`ifdef ME_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_MUL,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [K-1:0]  r_x;
  logic [K-1:0]  r_y;
  logic [K-1:0]  r_m;
  logic [K-1:0]  r_acc;
  logic [K-1:0]  r_mr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_idx;
  logic [JW-1:0] r_j;
  logic [W-1:0]  r_result;
  logic          r_valid;
  logic          r_last;
  logic          r_busy;
  logic          r_err;

  logic [K-1:0]  w_b_op;
  logic          w_b_bit;
  logic [K-1:0]  w_mr_nxt;
  logic          w_mul_done;
  logic          w_ybit;
  logic          w_idx_zero;
  logic          w_do_mul;
  logic          w_check_bad;
  logic          w_accept;
  logic [JW-1:0] w_j_nxt;

  // One interleaved multiply step: r' = (2r + b*a) mod m, with a working
  // width of K+2 bits so 2r and r+a never overflow. Since r, a < m, each
  // of the two conditional subtractions is enough to bring r back below m.
  function automatic logic [K-1:0] mod_step(input logic [K-1:0] r,
                                            input logic [K-1:0] a,
                                            input logic         bbit,
                                            input logic [K-1:0] m);
    logic [K+1:0] t;
    logic [K+1:0] mm;
    mm = {2'b00, m};
    t  = {1'b0, r, 1'b0};
    if (t >= mm) t = t - mm;
    if (bbit) t = t + {2'b00, a};
    if (t >= mm) t = t - mm;
    return t[K-1:0];
  endfunction

  function automatic logic [W-1:0] word_sel(input logic [K-1:0]  v,
                                            input logic [JW-1:0] j);
    return v[int'(j)*W +: W];
  endfunction

  // Squaring uses acc as both operands; multiply scans x against acc.
  assign w_b_op      = (r_state == S_MUL) ? r_x : r_acc;
  assign w_b_bit     = w_b_op[LAST_BIT - r_cnt];
  assign w_mr_nxt    = mod_step(r_mr, r_acc, w_b_bit, r_m);
  assign w_mul_done  = (r_cnt == LAST_BIT);
  assign w_ybit      = r_y[r_idx];
  assign w_idx_zero  = (r_idx == '0);
  assign w_do_mul    = CONST_TIME || w_ybit;
  assign w_check_bad = (r_m == '0) || (r_x >= r_m);
  assign w_accept    = r_valid & me_ready;
  assign w_j_nxt     = r_j + JW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (me_start) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_check_bad ? S_IDLE : S_SQR;
      S_SQR: begin
        if (w_mul_done) begin
          if (w_do_mul)        w_state_nxt = S_MUL;
          else if (w_idx_zero) w_state_nxt = S_OUT;
          else                 w_state_nxt = S_SQR;
        end
      end
      S_MUL: begin
        if (w_mul_done) w_state_nxt = w_idx_zero ? S_OUT : S_SQR;
      end
      S_OUT:   if (w_accept && r_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_mr     <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_j      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (me_start) begin
            r_x    <= me_x;
            r_y    <= me_y;
            r_m    <= me_m;
            r_busy <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_check_bad) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            // m == 1 makes every residue 0, including the empty product.
            r_acc <= (r_m == K'(1)) ? '0 : K'(1);
            r_idx <= LAST_BIT;
            r_mr  <= '0;
            r_cnt <= '0;
            r_j   <= '0;
          end
        end
        S_SQR, S_MUL: begin
          if (w_mul_done) begin
            r_mr  <= '0;
            r_cnt <= '0;
            // In constant-time builds the multiply always runs but its
            // product is only kept when the exponent bit is set.
            if (r_state == S_SQR || !CONST_TIME || w_ybit)
              r_acc <= w_mr_nxt;
            if (!w_idx_zero && (r_state == S_MUL || !w_do_mul))
              r_idx <= r_idx - CW'(1);
          end else begin
            r_mr  <= w_mr_nxt;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_OUT: begin
          if (!r_valid) begin
            r_result <= word_sel(r_acc, r_j);
            r_valid  <= 1'b1;
            r_last   <= (r_j == LAST_WORD);
          end else if (w_accept) begin
            if (r_last) begin
              r_result <= '0;
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              r_busy   <= 1'b0;
              r_j      <= '0;
            end else begin
              // Next word is presented immediately for full throughput.
              r_j      <= w_j_nxt;
              r_result <= word_sel(r_acc, w_j_nxt);
              r_last   <= (w_j_nxt == LAST_WORD);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign me_busy   = r_busy;
  assign me_err    = r_err;
  assign me_result = r_result;
  assign me_valid  = r_valid;
  assign me_last   = r_last;

endmodule

// File: tb/tb_me_stream_core.sv
// ---------------------------------------------------------------------------
// tb_me_stream_core
// Self-checking bench for me_stream_core with K = 8, W = 4. Expected results
// come from a plain repeated-multiplication model of x^y mod m, and expected
// latency from the popcount of the exponent.
// ---------------------------------------------------------------------------
module tb_me_stream_core;

  localparam int K  = 8;
  localparam int W  = 4;
  localparam int NW = K / W;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         me_start = 1'b0;
  logic [K-1:0] me_x     = '0;
  logic [K-1:0] me_y     = '0;
  logic [K-1:0] me_m     = '0;
  logic         me_ready = 1'b0;
  logic         me_busy;
  logic         me_err;
  logic [W-1:0] me_result;
  logic         me_valid;
  logic         me_last;

  int n_checks = 0;
  int n_pass   = 0;

  me_stream_core #(.K(K), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .me_start  (me_start),
    .me_x      (me_x),
    .me_y      (me_y),
    .me_m      (me_m),
    .me_busy   (me_busy),
    .me_err    (me_err),
    .me_result (me_result),
    .me_valid  (me_valid),
    .me_ready  (me_ready),
    .me_last   (me_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: x^y mod m by repeated multiplication.
  function automatic int model(input int x, input int y, input int m);
    int r;
    if (m == 1) return 0;
    r = 1;
    for (int i = 0; i < y; i++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int exp_latency(input int y);
    int p;
    p = 0;
    for (int i = 0; i < K; i++) p += (y >> i) & 1;
`ifdef ME_CONST_TIME_EN
    p = K;
`endif
    return 2 + K * K + p * K;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   me_busy,   0);
    check({tag, "_err"},    me_err,    0);
    check({tag, "_valid"},  me_valid,  0);
    check({tag, "_last"},   me_last,   0);
    check({tag, "_result"}, me_result, 0);
  endtask

  // mode: 0 ready held high, 1 random ready, 2 ready low for 5 cycles
  // once the first word is up, 3 ready high plus an ignored start mid-SQR.
  // rst_at: nonzero aborts the run with reset at that edge count.
  task automatic run_op(input int x, input int y, input int m,
                        input int mode, input int rst_at);
    int  n;
    int  j;
    int  guard;
    int  stall;
    int  res;
    bit  acc;
    me_x     = x[K-1:0];
    me_y     = y[K-1:0];
    me_m     = m[K-1:0];
    me_start = 1'b1;
    me_ready = (mode == 0 || mode == 3);
    step();
    me_start = 1'b0;
    check("busy_after_start", me_busy, 1);
    if (m == 0 || x >= m) begin
      step();
      check("err_pulse", me_err, 1);
      check("err_busy_low", me_busy, 0);
      check("err_no_valid", me_valid, 0);
      step();
      check("err_one_cycle", me_err, 0);
      for (int i = 0; i < 3; i++) check("err_valid_stays_low", me_valid, 0);
      return;
    end
    n = 0;
    while (!me_valid) begin
      if (n >= 2000) begin
        check("valid_timeout", 0, 1);
        return;
      end
      if (rst_at != 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          step();
          check("post_reset_valid", me_valid, 0);
        end
        check("post_reset_busy", me_busy, 0);
        return;
      end
      if (mode == 3 && n == 5) begin
        me_start = 1'b1;
        me_x     = 8'h03;
        me_y     = 8'hFF;
        me_m     = 8'h0B;
      end else if (mode == 3 && n == 6) begin
        me_start = 1'b0;
      end
      step();
      n++;
      if (!me_valid) begin
        check("busy_running", me_busy, 1);
        check("no_err_running", me_err, 0);
      end
    end
    check("latency", n, exp_latency(y));
    res   = model(x, y, m);
    j     = 0;
    guard = 0;
    stall = 0;
    while (j < NW) begin
      check("valid_held", me_valid, 1);
      check("word", me_result, (res >> (W * j)) & ((1 << W) - 1));
      check("last", me_last, (j == NW - 1));
      case (mode)
        1:       me_ready = 1'($urandom_range(0, 1));
        2:       me_ready = (stall >= 5);
        default: me_ready = 1'b1;
      endcase
      stall++;
      acc = me_ready && me_valid;
      step();
      if (acc) j++;
      guard++;
      if (guard > 200) begin
        check("word_timeout", 0, 1);
        break;
      end
    end
    check("done_valid_low", me_valid, 0);
    check("done_busy_low", me_busy, 0);
    check("done_last_low", me_last, 0);
    me_ready = 1'b0;
  endtask

  initial begin
    int m;
    int x;
    int y;
    // Hand-computed pins for the model itself.
    check("model_basic", model(16, 129, 225), 136);
    check("model_y0", model(5, 0, 7), 1);
    check("model_m1", model(0, 5, 1), 0);
`ifdef ME_CONST_TIME_EN
    check("latency_basic", exp_latency(129), 130);
`else
    check("latency_basic", exp_latency(129), 82);
`endif

    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("idle");

    run_op(8'h10, 8'h81, 8'hE1, 0, 0);   // basic: 0x88
    run_op(8'h05, 8'h00, 8'h07, 0, 0);   // zero exponent
    run_op(8'h00, 8'h05, 8'h01, 0, 0);   // unit modulus
    run_op(8'hE1, 8'h81, 8'hE1, 0, 0);   // x == m
    run_op(8'h05, 8'h81, 8'h00, 0, 0);   // m == 0
    run_op(8'h10, 8'h81, 8'hE1, 2, 0);   // backpressure
    run_op(8'h10, 8'h81, 8'hE1, 3, 0);   // ignored start while busy
    run_op(8'h10, 8'h81, 8'hE1, 0, 12);  // reset during first MUL
    run_op(8'h10, 8'h81, 8'hE1, 0, 0);   // fresh run after reset
    run_op(8'hFE, 8'hFF, 8'hFF, 1, 0);   // all-ones exponent, large values
    run_op(8'h07, 8'h80, 8'h0C, 1, 0);   // even modulus

    for (int it = 0; it < 25; it++) begin
      m = int'($urandom_range(1, 255));
      x = int'($urandom_range(0, m - 1));
      y = int'($urandom_range(0, 255));
      run_op(x, y, m, int'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/me_stream_core.md
# me_stream_core

Parametrised modular-exponentiation core for the RSA subsystem: computes x^y mod m for K-bit operands using left-to-right square-and-multiply over a bit-serial interleaved modular multiplier. It is the successor to the fixed-width exponentiation top. It adds:
- generic operand width and output word width;
- operand range checking with an error flag;
- a streamed, back-pressurable result port, so the core can feed a narrow bus interface or FIFO directly.

## Interface
Parameters:
- K, 2048, operand width in bits; K % W == 0, K >= 4
- W, 8, result stream word width in bits

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- me_start  in  1  start request; sampled only in IDLE
- me_x  in  K  base; must satisfy x < m
- me_y  in  K  exponent
- me_m  in  K  modulus; must be nonzero
- me_busy  out  1  high from the cycle after an accepted start until the last word is accepted or an error is reported
- me_err  out  1  one-cycle pulse: operand check failed
- me_result  out  W  current result word, least significant word first
- me_valid  out  1  me_result holds a valid word
- me_ready  in  1  downstream accepts the word when me_valid & me_ready
- me_last  out  1  high with the final word (word index K/W-1)

## Operation
- States: IDLE, CHECK, SQR, MUL, OUT.
- **IDLE**
  - On me_start = 1, register x, y and m into internal copies. Inputs may change afterwards.
  - Go to CHECK.
  - me_start in any other state is ignored.
- **CHECK** (1 cycle)
  - If m == 0 or x >= m: pulse me_err and return to IDLE. No output words are produced.
  - Otherwise, acc = (m == 1) ? 0 : 1, and bit index i = K-1.
  - Go to SQR.
- **SQR**: acc = acc·acc mod m. Then:
  - if y[i] = 1, go to MUL;
  - otherwise, if i == 0 go to OUT, else decrement i and go to SQR.
- **MUL**: acc = acc·x mod m. Then, if i == 0 go to OUT, else decrement i and go to SQR.
- **Modular multiply a·b mod m** (both operands < m): exactly K cycles, scanning b from MSB to LSB. Each cycle:
  - r = 2r; if r >= m then r -= m;
  - if b bit set then r += a; if r >= m then r -= m.
  - r starts at 0. The datapath is K+2 bits wide; both compare/subtract steps complete in the same cycle.
  - m does not need to be odd.
- **OUT**
  - Present word j = acc[W·j+W-1 : W·j], starting at j = 0.
  - Hold me_result, me_valid and me_last stable while me_ready = 0.
  - Advance j on me_valid & me_ready.
  - After word K/W-1 is accepted, go to IDLE and drop me_busy in that same cycle.
- y == 0 yields result 1 (or 0 when m == 1).

## Timing
- Reset values: me_busy = 0, me_err = 0, me_valid = 0, me_last = 0, me_result = 0. State is IDLE and all internal registers are 0.
- Reset assertion mid-operation aborts immediately. No partial output is produced after release.
- Let P = popcount(y) (P = K with ME_CONST_TIME_EN).
  - me_valid first rises exactly 2 + K·K + P·K clock edges after the edge that samples me_start.
  - The first word therefore appears at that edge count.
  - With me_ready held at 1, the words complete K/W cycles later.
- Error path: me_err is high for exactly the one cycle after CHECK (edge 2 after start). me_busy drops in the same cycle.
- me_start asserted in the same cycle the last word is accepted is ignored. A new start is accepted from the next cycle.

## Configuration
- **ME_CONST_TIME_EN defined**
  - MUL executes after every SQR regardless of y[i].
  - The product is written to acc only when y[i] = 1; otherwise it is discarded.
  - Latency is independent of y: 2 + 2·K·K.
- **ME_CONST_TIME_EN undefined**
  - MUL is skipped when y[i] = 0.
  - Latency depends on popcount(y), as given in Timing.

## Test plan
(K = 8 and W = 4 unless stated otherwise.)
- **Basic result**: x = 0x10, y = 0x81, m = 0xE1, me_ready = 1.
  - Words 0x8 then 0x8 (result 0x88 = 136); me_last on the second word.
  - First me_valid at edge 82 after start (130 with ME_CONST_TIME_EN).
- **Zero exponent and unit modulus**: y = 0x00, x = 0x05, m = 0x07 → words 0x1, 0x0. Then m = 0x01, x = 0x00, y = 0x05 → words 0x0, 0x0.
- **Range errors**: x = 0xE1, m = 0xE1 → me_err pulses one cycle, me_valid never rises, me_busy falls. Same with m = 0x00.
- **Backpressure**: run the basic case with me_ready = 0 for 5 cycles after me_valid rises. me_result = 0x8, me_valid = 1 and me_last = 0 must stay stable; the second word must not appear until the first is accepted.
- **Start while busy**: pulse me_start mid-SQR with different operands. The original result 0x88 is delivered unchanged.
- **Reset mid-operation**: assert rst_n = 0 during MUL. All outputs are 0 asynchronously. After release, a fresh start produces the correct 0x88 with the nominal latency.
